// File: rtl/fft_iter_pkg.sv
// fft_iter_pkg: state encoding, bit-reversal and timing helpers shared by the
// iterative FFT sequencer and its address delay line.
package fft_iter_pkg;

    typedef enum logic [2:0] {IDLE, RUN, DRAIN, GAP, DONE} state_e;

    function automatic int half_pts(input int awl);
        return 1 << (awl - 1);
    endfunction

    function automatic int stage_len(input int awl, input int lat);
        return half_pts(awl) + lat + 1;
    endfunction

    // Reverses the low w bits of v; bits at and above w come back as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] v, input int w);
        logic [31:0] r;
        logic [31:0] t;
        r = '0;
        t = v;
        for (int i = 0; i < 32; i++) begin
            if (i < w) begin
                r = {r[30:0], t[0]};
                t = t >> 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_addr_delay.sv
// fft_addr_delay: LAT-deep shift register carrying {valid, top, bot} from the
// read side of a stage to its write side.
module fft_addr_delay #(
    parameter int AWL = 8,
    parameter int LAT = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    input  logic [AWL-1:0] in_top,
    input  logic [AWL-1:0] in_bot,
    output logic           out_valid,
    output logic [AWL-1:0] out_top,
    output logic [AWL-1:0] out_bot
);

    logic [2*AWL:0] line_q [LAT];
    logic [2*AWL:0] line_d [LAT];

    always_comb begin
        line_d[0] = {in_valid, in_top, in_bot};
        for (int i = 1; i < LAT; i++) line_d[i] = line_q[i-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) line_q <= '{default: '0};
        else        line_q <= line_d;
    end

    assign {out_valid, out_top, out_bot} = line_q[LAT-1];

endmodule

// File: rtl/fft_iter_ctrl.sv
// fft_iter_ctrl: ping-pong stage/butterfly sequencer for an in-place radix-2 DIT FFT.
// Define FFT_ITER_CTRL_BITREV_EN to bit-reverse stage-0 reads so natural-order input is accepted.
module fft_iter_ctrl
    import fft_iter_pkg::*;
#(
    parameter int AWL = 8,
    parameter int LAT = 3
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   i_START,
    output logic                   o_BUSY,
    output logic                   o_DONE,
    output logic [$clog2(AWL)-1:0] o_STAGE,
    output logic                   o_RD_BANK,
    output logic                   o_RD_EN,
    output logic [AWL-1:0]         o_RD_ADDR_A,
    output logic [AWL-1:0]         o_RD_ADDR_B,
    output logic [AWL-2:0]         o_TW_ADDR,
    output logic                   o_WR_EN,
    output logic [AWL-1:0]         o_WR_ADDR_A,
    output logic [AWL-1:0]         o_WR_ADDR_B,
    output logic                   o_RESULT_BANK
);

    localparam int SW = $clog2(AWL);
    localparam int KW = AWL - 1;
    localparam int DW = $clog2(LAT + 1);
    localparam logic [KW-1:0] K_LAST = KW'(half_pts(AWL) - 1);
    localparam logic [DW-1:0] D_LAST = DW'(LAT - 1);
    localparam logic [SW-1:0] S_LAST = SW'(AWL - 1);
    localparam logic RES_BANK = 1'(AWL % 2);

    state_e        state_q, state_d;
    logic [SW-1:0] s_q, s_d;
    logic [KW-1:0] k_q, k_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          bank_q, bank_d;
    logic          res_q, res_d;

    logic           rd_en;
    logic [AWL-1:0] half, top, bot, rd_a, rd_b, dl_top, dl_bot;
    logic [KW-1:0]  pos, tw;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            s_q     <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
            bank_q  <= 1'b0;
            res_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            bank_q  <= bank_d;
            res_q   <= res_d;
        end
    end

    // The last stage skips GAP: the DONE cycle itself keeps the banks quiet.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        bank_d  = bank_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (i_START) begin
                    state_d = RUN;
                    s_d     = '0;
                    k_d     = '0;
                    bank_d  = 1'b0;
                    res_d   = 1'b0;
                end
            end
            RUN: begin
                k_d = k_q + 1'b1;
                if (k_q == K_LAST) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end
            end
            DRAIN: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == D_LAST) state_d = (s_q == S_LAST) ? DONE : GAP;
                if (cnt_q == D_LAST && s_q == S_LAST) res_d = RES_BANK;
            end
            GAP: begin
                state_d = RUN;
                s_d     = s_q + 1'b1;
                k_d     = '0;
                bank_d  = ~bank_q;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        half = AWL'(1) << s_q;
        pos  = k_q & ((KW'(1) << s_q) - 1'b1);
        top  = ((({1'b0, k_q} >> s_q) << 1) << s_q) | {1'b0, pos};
        bot  = top + half;
        tw   = pos << (KW - int'(s_q));
        rd_a = top;
        rd_b = bot;
`ifdef FFT_ITER_CTRL_BITREV_EN
        if (s_q == '0) begin
            rd_a = AWL'(bitrev(32'({k_q, 1'b0}), AWL));
            rd_b = AWL'(bitrev(32'({k_q, 1'b1}), AWL));
        end
`endif
    end

    assign rd_en  = state_q == RUN;
    assign dl_top = rd_en ? top : '0;
    assign dl_bot = rd_en ? bot : '0;

    fft_addr_delay #(.AWL(AWL), .LAT(LAT)) u_delay (
        .clk      (CLK),
        .rst_n    (RST),
        .in_valid (rd_en),
        .in_top   (dl_top),
        .in_bot   (dl_bot),
        .out_valid(o_WR_EN),
        .out_top  (o_WR_ADDR_A),
        .out_bot  (o_WR_ADDR_B)
    );

    assign o_BUSY        = state_q != IDLE;
    assign o_DONE        = state_q == DONE;
    assign o_STAGE       = s_q;
    assign o_RD_BANK     = bank_q;
    assign o_RD_EN       = rd_en;
    assign o_RD_ADDR_A   = rd_en ? rd_a : '0;
    assign o_RD_ADDR_B   = rd_en ? rd_b : '0;
    assign o_TW_ADDR     = rd_en ? tw : '0;
    assign o_RESULT_BANK = res_q;

endmodule

// File: tb/tb_fft_iter_ctrl.sv
// tb_fft_iter_ctrl: checks fft_iter_ctrl (AWL=3, LAT=2) against a schedule model indexed
// by the cycle count of a run, plus literal address tables and timing figures.
module tb_fft_iter_ctrl;

    localparam int AWL = 3;
    localparam int LAT = 2;
    localparam int N   = 1 << AWL;
    localparam int H   = N / 2;
    localparam int L   = H + LAT + 1;
    localparam int TOT = AWL * L;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       i_START = 1'b0;
    logic       o_BUSY, o_DONE, o_RD_BANK, o_RD_EN, o_WR_EN, o_RESULT_BANK;
    logic [1:0] o_STAGE, o_TW_ADDR;
    logic [2:0] o_RD_ADDR_A, o_RD_ADDR_B, o_WR_ADDR_A, o_WR_ADDR_B;

    int checks = 0;
    int failures = 0;

    int PA [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int PB [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
`ifdef FFT_ITER_CTRL_BITREV_EN
    int RA [12] = '{0, 2, 1, 3, 0, 1, 4, 5, 0, 1, 2, 3};
    int RB [12] = '{4, 6, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
`else
    int RA [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int RB [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
`endif
    int TW [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
    int BK [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};

    fft_iter_ctrl #(.AWL(AWL), .LAT(LAT)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .i_START      (i_START),
        .o_BUSY       (o_BUSY),
        .o_DONE       (o_DONE),
        .o_STAGE      (o_STAGE),
        .o_RD_BANK    (o_RD_BANK),
        .o_RD_EN      (o_RD_EN),
        .o_RD_ADDR_A  (o_RD_ADDR_A),
        .o_RD_ADDR_B  (o_RD_ADDR_B),
        .o_TW_ADDR    (o_TW_ADDR),
        .o_WR_EN      (o_WR_EN),
        .o_WR_ADDR_A  (o_WR_ADDR_A),
        .o_WR_ADDR_B  (o_WR_ADDR_B),
        .o_RESULT_BANK(o_RESULT_BANK)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d want %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int top_of(input int s, input int k);
        int h = 1 << s;
        return (k / h) * 2 * h + k % h;
    endfunction

    function automatic int rev_of(input int v);
        int r = 0;
        for (int i = 0; i < AWL; i++) r = r * 2 + (v / (1 << i)) % 2;
        return r;
    endfunction

    // Model: mc is the cycle index within a run (0 = first RUN cycle), -1 when idle.
    int   mc = -1;
    logic resv = 1'b0;
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            mc   <= -1;
            resv <= 1'b0;
        end else if (mc < 0) begin
            mc <= i_START ? 0 : -1;
            if (i_START) resv <= 1'b0;
        end else begin
            mc <= (mc == TOT - 1) ? -1 : mc + 1;
            if (mc == TOT - 1) resv <= 1'b1;
        end
    end

    always @(negedge CLK) begin
        if (RST) begin
            int st, cc, k, h, ea, eb;
            logic busy, rd, wr;
            busy = mc >= 0;
            st   = busy ? mc / L : 0;
            cc   = busy ? mc % L : 0;
            h    = 1 << st;
            rd   = busy && cc < H;
            wr   = busy && cc >= LAT && cc < H + LAT;
            chk("busy", 32'(o_BUSY), 32'(busy));
            chk("done", 32'(o_DONE), 32'(mc == TOT - 1));
            chk("rd_en", 32'(o_RD_EN), 32'(rd));
            chk("wr_en", 32'(o_WR_EN), 32'(wr));
            if (busy) begin
                chk("stage", 32'(o_STAGE), st);
                chk("rd_bank", 32'(o_RD_BANK), st % 2);
            end
            if (rd) begin
                k  = cc;
                ea = top_of(st, k);
                eb = ea + h;
`ifdef FFT_ITER_CTRL_BITREV_EN
                if (st == 0) begin
                    ea = rev_of(2 * k);
                    eb = rev_of(2 * k + 1);
                end
`endif
                chk("rd_addr_a", 32'(o_RD_ADDR_A), ea);
                chk("rd_addr_b", 32'(o_RD_ADDR_B), eb);
                chk("tw_addr", 32'(o_TW_ADDR), (k % h) * (H / h));
            end
            if (wr) begin
                k = cc - LAT;
                chk("wr_addr_a", 32'(o_WR_ADDR_A), top_of(st, k));
                chk("wr_addr_b", 32'(o_WR_ADDR_B), top_of(st, k) + h);
            end
            if (mc == TOT - 1 || (mc < 0 && resv))
                chk("result_bank", 32'(o_RESULT_BANK), AWL % 2);
        end
    end

    // Capture of each run as seen on the DUT pins, restarted when o_BUSY rises.
    logic busy_d = 1'b0;
    logic res_at_done = 1'b0;
    int rd_n = 0, wr_n = 0, done_n = 0, done_at = -1, cyc = 0;
    int wcnt [AWL];
    int cap_a [12], cap_b [12], cap_t [12], cap_bk [12], cap_wa [12], cap_wb [12];
    always @(negedge CLK) begin
        if (RST) begin
            if (o_BUSY && !busy_d) begin
                rd_n = 0; wr_n = 0; done_n = 0; done_at = -1; cyc = 0;
                foreach (wcnt[i]) wcnt[i] = 0;
            end else begin
                cyc++;
            end
            if (o_RD_EN) begin
                if (rd_n < 12) begin
                    cap_a[rd_n]  = int'(o_RD_ADDR_A);
                    cap_b[rd_n]  = int'(o_RD_ADDR_B);
                    cap_t[rd_n]  = int'(o_TW_ADDR);
                    cap_bk[rd_n] = int'(o_RD_BANK);
                end
                rd_n++;
            end
            if (o_WR_EN) begin
                if (wr_n < 12) begin
                    cap_wa[wr_n] = int'(o_WR_ADDR_A);
                    cap_wb[wr_n] = int'(o_WR_ADDR_B);
                end
                if (cyc / L < AWL) wcnt[cyc / L]++;
                wr_n++;
            end
            if (o_DONE) begin
                done_n++;
                done_at = cyc;
                res_at_done = o_RESULT_BANK;
            end
        end
        busy_d = o_BUSY;
    end

    task automatic pulse_start();
        @(posedge CLK); #1 i_START = 1'b1;
        @(posedge CLK); #1 i_START = 1'b0;
    endtask

    task automatic wait_mc(input int v);
        int n = 0;
        while (mc != v && n < 200) begin
            @(negedge CLK);
            n++;
        end
        chk("reach_cycle", mc, v);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!o_DONE && n < 200) begin
            @(negedge CLK);
            n++;
        end
        chk("done_seen", 32'(o_DONE), 1);
        repeat (3) @(negedge CLK);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 32'(o_BUSY), 0);
        chk({tag, "_done"}, 32'(o_DONE), 0);
        chk({tag, "_stage"}, 32'(o_STAGE), 0);
        chk({tag, "_rd_bank"}, 32'(o_RD_BANK), 0);
        chk({tag, "_rd_en"}, 32'(o_RD_EN), 0);
        chk({tag, "_rd_a"}, 32'(o_RD_ADDR_A), 0);
        chk({tag, "_rd_b"}, 32'(o_RD_ADDR_B), 0);
        chk({tag, "_tw"}, 32'(o_TW_ADDR), 0);
        chk({tag, "_wr_en"}, 32'(o_WR_EN), 0);
        chk({tag, "_wr_a"}, 32'(o_WR_ADDR_A), 0);
        chk({tag, "_wr_b"}, 32'(o_WR_ADDR_B), 0);
        chk({tag, "_result"}, 32'(o_RESULT_BANK), 0);
    endtask

    task automatic check_run(input string tag);
        chk({tag, "_n_reads"}, rd_n, 12);
        chk({tag, "_n_writes"}, wr_n, 12);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("%s_rd_a[%0d]", tag, i), cap_a[i], RA[i]);
            chk($sformatf("%s_rd_b[%0d]", tag, i), cap_b[i], RB[i]);
            chk($sformatf("%s_tw[%0d]", tag, i), cap_t[i], TW[i]);
            chk($sformatf("%s_bank[%0d]", tag, i), cap_bk[i], BK[i]);
            chk($sformatf("%s_wr_a[%0d]", tag, i), cap_wa[i], PA[i]);
            chk($sformatf("%s_wr_b[%0d]", tag, i), cap_wb[i], PB[i]);
        end
        for (int s = 0; s < AWL; s++) chk($sformatf("%s_writes_stage%0d", tag, s), wcnt[s], 4);
        chk({tag, "_done_cycle"}, done_at, 20);
        chk({tag, "_done_pulses"}, done_n, 1);
        chk({tag, "_result_bank"}, 32'(res_at_done), 1);
    endtask

    initial begin
        #2 RST = 1'b0;
        #2 chk_zero("reset");
        repeat (2) @(posedge CLK);
        #1 RST = 1'b1;
        repeat (3) @(posedge CLK);

        pulse_start();
        wait_done();
        check_run("run1");

        // Start requests while busy must be dropped, not queued.
        pulse_start();
        wait_mc(1);
        i_START = 1'b1;
        @(posedge CLK); #1 i_START = 1'b0;
        wait_mc(4);
        i_START = 1'b1;
        @(posedge CLK); #1 i_START = 1'b0;
        wait_done();
        repeat (20) @(negedge CLK);
        chk("busy_start_done_pulses", done_n, 1);
        chk("busy_start_idle", 32'(o_BUSY), 0);

        // Abort in stage 1, cycle 2, between clock edges.
        pulse_start();
        wait_mc(L + 2);
        #1 RST = 1'b0;
        #1 chk_zero("abort");
        repeat (2) @(posedge CLK);
        #1 RST = 1'b1;
        repeat (10) begin
            @(negedge CLK);
            chk("post_reset_wr_en", 32'(o_WR_EN), 0);
        end

        pulse_start();
        wait_done();
        check_run("run_after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
